// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer: sequences one source-strobe / destination-load transfer on the shared bus
module bus_xfer_sequencer #(
  parameter int WAIT_MAX = 8,
  parameter int NSRC     = 24
) (
  input  logic            clock,
  input  logic            clear_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      src_code,
  input  logic [4:0]      dst_code,
  input  logic            mdr_valid,
  output logic [NSRC-1:0] src_out,
  output logic [NSRC-1:0] dst_in,
  output logic            done,
  output logic            error
);
  typedef enum logic [2:0] {IDLE, DRIVE, LOAD, DONE, ERR} state_t;
  localparam logic [NSRC-1:0] ONE = {{(NSRC-1){1'b0}}, 1'b1};
  state_t     state, nstate;
  logic [4:0] src_q, dst_q, s_n, d_n;
  logic [3:0] cnt, cnt_n;
  logic       accept, legal, mdr_src, timeout;
  always_comb begin
    accept  = req_valid && state == IDLE;
    s_n     = accept ? src_code : src_q;
    d_n     = accept ? dst_code : dst_q;
    legal   = src_code <= 5'd23 && (dst_code <= 5'd17 || dst_code == 5'd20 || dst_code == 5'd21);
    mdr_src = src_q == 5'd21;
    timeout = int'(cnt) + 1 >= WAIT_MAX;
    nstate  = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (accept) nstate = legal ? DRIVE : ERR;
      end
      DRIVE: begin
        if (!mdr_src || mdr_valid) nstate = LOAD;
        else begin
          cnt_n  = cnt == 4'hf ? cnt : cnt + 4'd1;
          nstate = timeout ? ERR : DRIVE;
        end
      end
      LOAD:    nstate = DONE;
      DONE:    nstate = IDLE;
      ERR: begin
        cnt_n  = '0;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt       <= '0;
      src_out   <= '0;
      dst_in    <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= nstate;
      src_q     <= s_n;
      dst_q     <= d_n;
      cnt       <= cnt_n;
      src_out   <= (nstate == DRIVE || nstate == LOAD) ? ONE << s_n : '0;
      dst_in    <= nstate == LOAD ? ONE << d_n : '0;
      done      <= nstate == DONE;
      error     <= nstate == ERR;
      req_ready <= nstate == IDLE;
    end
  end
endmodule

// File: doc/bus_xfer_sequencer.md
Name: bus_xfer_sequencer

Overview:
- Sequences one register-to-register transfer across the shared 32-bit datapath bus.
- Takes a request with a source code and a destination code. Drives exactly one source "out" strobe onto the bus-select encoder. Then pulses exactly one destination "in" enable, so the receiving register captures the bus value.
- Sits between the control unit and the register/bus fabric. It is the load side of the bus: the bus mux decides who talks, this block decides when the listener latches.

Parameters:
- WAIT_MAX, 8: maximum cycles held in DRIVE waiting for mdr_valid when the source is MDR; exceeding it aborts with error.
- NSRC, 24: number of one-hot source/destination lines. Fixed at 24; it is a parameter only for documentation.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  transfer request present.
- req_ready  out  1  block idle and able to accept a request.
- src_code  in  5  source: 0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C.
- dst_code  in  5  destination, same numbering as src_code.
- mdr_valid  in  1  memory data in MDR is stable; only consulted when the source is 21.
- src_out  out  24  one-hot out-strobes; bit n corresponds to code n.
- dst_in  out  24  one-hot in-enables; bit n corresponds to code n.
- done  out  1  one-cycle pulse: transfer completed.
- error  out  1  one-cycle pulse: request rejected or timed out.

Behaviour:
- Reset: while clear_n is low, asynchronously force:
  - state = IDLE
  - src_out = 0, dst_in = 0, done = 0, error = 0
  - req_ready = 1 after release
  - wait counter = 0
  Reset mid-transfer abandons the transfer with no done and no error pulse.
- Legal destination codes: 0-17, 20, 21.
- Illegal destination codes are 18, 19, 22, 23 and 24-31. Reasons: Z is loaded only by the ALU, InPort and C are sources only, and 24-31 are undefined.
- Source codes 24-31 are illegal.
- src_code == dst_code is legal; the register reloads itself.
- Handshake: a request is accepted when req_valid && req_ready at a rising edge. src_code and dst_code are registered at acceptance. Later input changes are ignored. req_ready is 1 only in IDLE.
- States:
  - IDLE:
    - On accept with legal codes, go to DRIVE.
    - On accept with an illegal code, go to ERR.
  - DRIVE:
    - src_out = onehot(src), dst_in = 0.
    - Non-MDR source: go to LOAD after 1 cycle.
    - MDR source: remain while mdr_valid is 0 and increment the wait counter. Go to LOAD on the first cycle mdr_valid is 1.
    - If the counter reaches WAIT_MAX with mdr_valid still 0, go to ERR.
  - LOAD: src_out held, dst_in = onehot(dst) for exactly 1 cycle, then go to DONE.
  - DONE: src_out = 0, dst_in = 0, done = 1 for 1 cycle, then go to IDLE.
  - ERR: all strobes 0, error = 1 for 1 cycle, wait counter cleared, then go to IDLE.
- Latency, non-MDR source, accept at edge 0:
  - DRIVE in cycle 1
  - LOAD (dst_in high) in cycle 2
  - done in cycle 3
  - req_ready back in cycle 4
  - Back-to-back throughput is one transfer per 4 cycles.
- Invariants:
  - src_out and dst_in are each zero or exactly one-hot.
  - dst_in is never asserted unless src_out is asserted in the same cycle.
  - done and error are never both 1.
- All outputs are registered; there is no combinational path from inputs to src_out, dst_in, done or error.
- The wait counter is 4 bits wide, saturates, and is cleared on entry to DRIVE.

Test Plan:
1. Reset, then R3→R7 (src 3, dst 7). Required: req_ready drops at cycle 1. src_out = 0x000008 in cycles 1-2. dst_in = 0x000080 only in cycle 2. done pulses in cycle 3. req_ready = 1 in cycle 4.
2. MDR→PC (src 21, dst 20) with mdr_valid low for 3 cycles, then high. Required: DRIVE lasts 4 cycles. dst_in = 0x100000 in the cycle after mdr_valid rises. Then done.
3. MDR→R1 with mdr_valid held low. Required: after WAIT_MAX = 8 DRIVE cycles, error pulses once. No dst_in bit is ever set. req_ready returns.
4. Illegal dst_code 18 (Zhigh), then dst_code 23 (C). Required: for each request, error at cycle 1, zero strobes throughout, req_ready back at cycle 2.
5. Assert clear_n low during the LOAD cycle of HI→LO (src 16, dst 17). Required: src_out and dst_in go to 0 immediately without waiting for a clock edge. No done pulse. req_ready = 1 after release.
6. req_valid held high with two queued requests, C→R0 then R0→MDR. Required: second accepted exactly 4 cycles after the first. Source/destination changes during the first transfer have no effect on it. Invariants hold every cycle.
